input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce_pkg.sv | 12 +
 rtl/input_debounce_sync2.sv | 22 ++
 rtl/input_debounce.sv | 127 ++++++++++++
 tb/tb_input_debounce.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/input_debounce_pkg.sv
// Shared types and default parameters for the input_debounce block.
package input_debounce_pkg;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int GCNT_W_DEF     = 8;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_e;

endpackage : input_debounce_pkg

// File: rtl/input_debounce_sync2.sv
// Two-flop synchronizer for bringing an asynchronous line into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[0], d};
        end
    end

    assign q = ff_q[1];

endmodule : sync2

// File: rtl/input_debounce.sv
// Debouncer: synchronizes raw_in and accepts a level change only after DEB_CYCLES stable samples.
// Optional rejected-change counter on glitch_cnt when INPUT_DEBOUNCE_GLITCH_CNT_EN is defined.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int GCNT_W     = GCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              raw_in,
    output logic              ina,
    output logic              rise,
    output logic              fall,
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    output logic              busy,
    output logic [GCNT_W-1:0] glitch_cnt
`else
    output logic              busy
`endif
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ina_q,   ina_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             accept;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (s)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ina_d   = ina_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != ina_q) begin
                    // With a single-sample window the first differing sample is already enough.
                    if (DEB_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                if (s == ina_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d = STABLE;
            cnt_d   = '0;
            ina_d   = s;
            rise_d  = s;
            fall_d  = ~s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            ina_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ina_q   <= ina_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign ina  = ina_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == CHECK);

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic              glitch_evt;
    logic [GCNT_W-1:0] gcnt_q;

    // A candidate that reverts before qualification is a glitch, including on the final sample.
    assign glitch_evt = (state_q == CHECK) && (s == ina_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q <= '0;
        end else if (glitch_evt && (gcnt_q != '1)) begin
            gcnt_q <= gcnt_q + GCNT_W'(1);
        end
    end

    assign glitch_cnt = gcnt_q;
`endif

endmodule : input_debounce

// File: tb/tb_input_debounce.sv
// Directed self-checking bench for input_debounce (default, single-cycle and saturating-counter builds).
module tb_input_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst, raw, ina, rise, fall, busy;
    logic rst_f, raw_f, ina_f, rise_f, fall_f, busy_f;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gcnt, gcnt_f;
    logic       rst_s, raw_s, ina_s, rise_s, fall_s, busy_s;
    logic [1:0] gcnt_s;
    logic [1:0] sat_exp [5];
`endif

    input_debounce u_dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw),
        .ina        (ina),
        .rise       (rise),
        .fall       (fall),
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        .busy       (busy),
        .glitch_cnt (gcnt)
`else
        .busy       (busy)
`endif
    );

    input_debounce #(.DEB_CYCLES(1)) u_fast (
        .clk        (clk),
        .rst        (rst_f),
        .raw_in     (raw_f),
        .ina        (ina_f),
        .rise       (rise_f),
        .fall       (fall_f),
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        .busy       (busy_f),
        .glitch_cnt (gcnt_f)
`else
        .busy       (busy_f)
`endif
    );

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    input_debounce #(.DEB_CYCLES(2), .GCNT_W(2)) u_sat (
        .clk        (clk),
        .rst        (rst_s),
        .raw_in     (raw_s),
        .ina        (ina_s),
        .rise       (rise_s),
        .fall       (fall_s),
        .busy       (busy_s),
        .glitch_cnt (gcnt_s)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1; raw   = 1'b0;
        rst_f = 1'b1; raw_f = 1'b0;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        rst_s = 1'b1; raw_s = 1'b0;
`endif
        tick();
        tick();

        check("reset ina",  32'(ina),  32'd0);
        check("reset rise", 32'(rise), 32'd0);
        check("reset fall", 32'(fall), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("reset gcnt", 32'(gcnt), 32'd0);
`endif

        // Release reset with raw high: ina rises at edge 6, busy after edges 3..5.
        rst = 1'b0;
        raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rise_path e%0d ina", e),  32'(ina),  32'(e >= 6));
            check($sformatf("rise_path e%0d rise", e), 32'(rise), 32'(e == 6));
            check($sformatf("rise_path e%0d fall", e), 32'(fall), 32'd0);
            check($sformatf("rise_path e%0d busy", e), 32'(busy), 32'(e >= 3 && e <= 5));
        end

        // Falling qualification from ina=1.
        raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("fall_path e%0d ina", e),  32'(ina),  32'(e < 6));
            check($sformatf("fall_path e%0d fall", e), 32'(fall), 32'(e == 6));
            check($sformatf("fall_path e%0d rise", e), 32'(rise), 32'd0);
            check($sformatf("fall_path e%0d busy", e), 32'(busy), 32'(e >= 3 && e <= 5));
        end

        // Reset while qualifying (counter at 2 after edge 4).
        raw = 1'b1;
        repeat (4) tick();
        check("midcheck busy", 32'(busy), 32'd1);
        check("midcheck ina",  32'(ina),  32'd0);
        rst = 1'b1;
        tick();
        check("midrst ina",  32'(ina),  32'd0);
        check("midrst rise", 32'(rise), 32'd0);
        check("midrst fall", 32'(fall), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("postrst e%0d ina", e),  32'(ina),  32'd0);
            check($sformatf("postrst e%0d rise", e), 32'(rise), 32'd0);
            check($sformatf("postrst e%0d busy", e), 32'(busy), 32'd0);
        end
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("postrst gcnt", 32'(gcnt), 32'd0);
`endif

        // Three-cycle pulse reverts on the edge the counter would reach DEB_CYCLES.
        raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("glitch e%0d ina", e),  32'(ina),  32'd0);
            check($sformatf("glitch e%0d rise", e), 32'(rise), 32'd0);
            check($sformatf("glitch e%0d busy", e), 32'(busy), 32'(e >= 3 && e <= 5));
            if (e == 3) raw = 1'b0;
        end
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        check("glitch gcnt", 32'(gcnt), 32'd1);
`endif

        // Single-sample window: change accepted at edge 3, never busy.
        rst_f = 1'b0;
        raw_f = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("fast e%0d ina", e),  32'(ina_f),  32'(e >= 3));
            check($sformatf("fast e%0d rise", e), 32'(rise_f), 32'(e == 3));
            check($sformatf("fast e%0d busy", e), 32'(busy_f), 32'd0);
        end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        // Two-bit counter saturates at 3.
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        rst_s = 1'b0;
        tick();
        for (int g = 0; g < 5; g++) begin
            raw_s = 1'b1;
            tick();
            raw_s = 1'b0;
            repeat (5) tick();
            check($sformatf("sat g%0d gcnt", g), 32'(gcnt_s), 32'(sat_exp[g]));
            check($sformatf("sat g%0d ina", g),  32'(ina_s),  32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_input_debounce
